nco_sincos: RTL and testbench
=============================

Name: nco_sincos

Overview:
- Numerically controlled oscillator producing quadrature sine/cosine samples, one per enabled clock.
- Phase is set by a 32-bit tuning word.
- Sits ahead of the DAC driver in the sine-generator path.
- At clk = 125 MHz, phi_inc_i = 687 (0x2AF) gives ≈20.0 Hz (f = phi_inc_i × f_clk / 2^32).

Parameters:
- ACC_W, 32, phase accumulator / tuning word width.
- ADDR_W, 12, truncated phase width used for the table lookup (2 quadrant bits + 10 index bits).
- OUT_W, 14, output sample width, two's complement.

Ports:
- clk  in  1  clock; reset_n synchronous, active-low.
- reset_n  in  1  synchronous active-low reset.
- clken  in  1  clock enable; all state advances only when 1.
- phi_inc_i  in  ACC_W  phase increment (tuning word), unsigned.
- fsin_o  out  OUT_W  sine sample, two's complement.
- fcos_o  out  OUT_W  cosine sample, two's complement.
- out_valid  out  1  fsin_o/fcos_o hold a valid sample.

Behaviour:
- Reset (reset_n=0 at a clk edge): acc=0, pipeline regs=0, fsin_o=0, fcos_o=0, out_valid=0. Reset has priority over clken.
- All registers update only on clk edges with clken=1 and reset_n=1; with clken=0 everything holds, including out_valid.
- Stage 1 (accumulator): acc <= acc + phi_inc_i, mod 2^ACC_W, wrapping silently. The stage also registers p = acc[31:20] (pre-increment value), so the first sample after reset is phase 0.
- Stage 2 (lookup): q = p[11:10], j = p[9:0].
  - Quarter table T[i] = round(8191·sin(π/2·i/1024)) for i = 0..1024 (1025 entries; T[0]=0, T[1024]=8191).
  - mag(q,j): q even -> T[j]; q odd -> T[1024-j].
  - sign: q<2 -> positive, q≥2 -> negative.
  - sine uses p; cosine uses p+1024 (mod 4096). Magnitudes and signs are registered.
- Stage 3 (output): fsin_o/fcos_o <= signed result. Negate in two's complement. Range is ±8191; -8192 never produced.
- Latency: 3 enabled cycles from phase capture to output.
- out_valid: 3-bit shift register of 1s cleared by reset. It rises on the 3rd enabled edge after reset release and stays 1 until the next reset.
- Tuning word changes take effect on the next enabled edge; no glitch; phase is continuous.
- Reset mid-operation: the next edge returns to the reset state; the sequence restarts at phase 0.

Optional Feature:
- Macro NCO_PHASE_OFFSET_EN.
- When defined: adds input phi_ofs_i [ACC_W-1:0]. Stage 1 captures p = (acc + phi_ofs_i)[31:20]; the accumulator itself is unaffected. Used for static phase shift or phase modulation.
- When undefined: the port is absent and p = acc[31:20].

Decomposition:
- Package nco_pkg: ACC_W, ADDR_W, OUT_W, QTR_LEN=1024, AMP_MAX=8191, and a function generating T[i] (or a constant table).
- One sub-module, nco_quarter_rom: registered dual-read quarter-wave ROM. Inputs are two 10/11-bit indices; outputs are two 13-bit magnitudes.

Test Plan:
- Reset: hold reset_n=0 for 7 cycles, clken=1, phi=0x2AF, then release -> out_valid=0 on the 1st and 2nd edges after release, =1 from the 3rd. First sample sin=0, cos=8191.
- Quarter-rate: phi=0x40000000 -> sin sequence 0, 8191, 0, -8191 repeating; cos 8191, 0, -8191, 0.
- DC: phi=0 -> sin=0, cos=8191 constant while valid.
- Slow tone: phi=0x2AF -> p increments roughly every 1526 cycles. sin is non-decreasing over the first 1/4 period; first nonzero sin after 1527 cycles. Wrap of acc after 2^32/687 ≈ 6.25M samples is seamless.
- clken: with phi=0x40000000, drop clken for 5 cycles mid-run -> outputs and out_valid frozen; the sequence resumes exactly where it stopped.
- Mid-run reset: assert reset_n=0 for 1 cycle -> outputs 0, out_valid 0. Restart gives sin=0, cos=8191 as the first valid sample.

Source files
------------

// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, amplitude constants and the quarter-wave sine generator.
package nco_pkg;
  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 12;
  localparam int OUT_W   = 14;
  localparam int QTR_LEN = 1024;
  localparam int AMP_MAX = 8191;
  // Quarter-wave table entry: round(AMP_MAX * sin(pi/2 * i / QTR_LEN)), always non-negative.
  function automatic logic [12:0] qsin(int i);
    return 13'($rtoi(real'(AMP_MAX) * $sin(3.14159265358979 * real'(i) / real'(2 * QTR_LEN)) + 0.5));
  endfunction
endpackage

// File: rtl/nco_quarter_rom.sv
// nco_quarter_rom: registered dual-read quarter-wave magnitude ROM (1025 entries, 13-bit).
module nco_quarter_rom
  import nco_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic [10:0] idx_a_i,
  input  logic [10:0] idx_b_i,
  output logic [12:0] mag_a_o,
  output logic [12:0] mag_b_o
);
  logic [12:0] rom [0:QTR_LEN];
  logic [12:0] mag_a_d, mag_a_q, mag_b_d, mag_b_q;
  for (genvar i = 0; i <= QTR_LEN; i++) begin : g_rom
    assign rom[i] = qsin(i);
  end
  // Look up both magnitudes, holding them while the clock enable is low.
  always_comb begin
    mag_a_d = clken ? rom[idx_a_i] : mag_a_q;
    mag_b_d = clken ? rom[idx_b_i] : mag_b_q;
  end
  // Read registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
    end
  end
  assign mag_a_o = mag_a_q;
  assign mag_b_o = mag_b_q;
endmodule

// File: rtl/nco_sincos.sv
// nco_sincos: 3-stage quadrature NCO (accumulate, quarter-wave lookup, sign apply); NCO_PHASE_OFFSET_EN adds phi_ofs_i.
module nco_sincos
  import nco_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [ACC_W-1:0] phi_inc_i,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0] phi_ofs_i,
`endif
  output logic [OUT_W-1:0] fsin_o,
  output logic [OUT_W-1:0] fcos_o,
  output logic             out_valid
);
  logic [ACC_W-1:0]  acc_d, acc_q, ph;
  logic [ADDR_W-1:0] p_d, p_q, pc;
  logic [10:0]       sidx, cidx;
  logic [12:0]       smag, cmag;
  logic              sneg_d, sneg_q, cneg_d, cneg_q;
  logic [OUT_W-1:0]  fsin_d, fsin_q, fcos_d, fcos_q;
  logic [2:0]        vld_d, vld_q;
`ifdef NCO_PHASE_OFFSET_EN
  assign ph = acc_q + phi_ofs_i;
`else
  assign ph = acc_q;
`endif
  // Next-state for all stages; odd quadrants read the table mirrored, cosine leads sine by a quarter turn.
  always_comb begin
    pc     = p_q + 12'(QTR_LEN);
    sidx   = p_q[10] ? 11'(QTR_LEN) - {1'b0, p_q[9:0]} : {1'b0, p_q[9:0]};
    cidx   = pc[10] ? 11'(QTR_LEN) - {1'b0, pc[9:0]} : {1'b0, pc[9:0]};
    acc_d  = clken ? acc_q + phi_inc_i : acc_q;
    p_d    = clken ? ph[ACC_W-1 -: ADDR_W] : p_q;
    sneg_d = clken ? p_q[ADDR_W-1] : sneg_q;
    cneg_d = clken ? pc[ADDR_W-1] : cneg_q;
    fsin_d = clken ? (sneg_q ? -OUT_W'(smag) : OUT_W'(smag)) : fsin_q;
    fcos_d = clken ? (cneg_q ? -OUT_W'(cmag) : OUT_W'(cmag)) : fcos_q;
    vld_d  = clken ? {vld_q[1:0], 1'b1} : vld_q;
  end
  // Pipeline registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      p_q    <= '0;
      sneg_q <= 1'b0;
      cneg_q <= 1'b0;
      fsin_q <= '0;
      fcos_q <= '0;
      vld_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      p_q    <= p_d;
      sneg_q <= sneg_d;
      cneg_q <= cneg_d;
      fsin_q <= fsin_d;
      fcos_q <= fcos_d;
      vld_q  <= vld_d;
    end
  end
  nco_quarter_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .idx_a_i (sidx),
    .idx_b_i (cidx),
    .mag_a_o (smag),
    .mag_b_o (cmag)
  );
  assign fsin_o    = fsin_q;
  assign fcos_o    = fcos_q;
  assign out_valid = vld_q[2];
endmodule

// File: tb/tb_nco_sincos.sv
// tb_nco_sincos: scoreboard bench for nco_sincos with hand-computed sample sequences.
module tb_nco_sincos;
  logic        clk = 1'b0;
  logic        reset_n, clken;
  logic [31:0] phi_inc_i;
  logic [13:0] fsin_o, fcos_o;
  logic        out_valid;
`ifdef NCO_PHASE_OFFSET_EN
  logic [31:0] phi_ofs_i = '0;
`endif

  nco_sincos dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
`ifdef NCO_PHASE_OFFSET_EN
    .phi_ofs_i (phi_ofs_i),
`endif
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int c; } smp_t;
  smp_t q[$];
  smp_t last = '{0, 0};
  int   n_chk = 0, n_fail = 0;
  logic fire;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor: every enabled, non-reset edge that leaves out_valid high presents one sample.
  always @(posedge clk) begin
    fire = clken && reset_n;
    #1;
    if (fire && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        last = q.pop_front();
        chk("fsin", int'($signed(fsin_o)), last.s);
        chk("fcos", int'($signed(fcos_o)), last.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(int n);
    reset_n = 1'b0;
    repeat (n) tick();
    q.delete();
    chk("rst_fsin", int'(fsin_o), 0);
    chk("rst_fcos", int'(fcos_o), 0);
    chk("rst_valid", int'(out_valid), 0);
    reset_n = 1'b1;
  endtask

  task automatic push(int s, int c);
    q.push_back('{s, c});
  endtask

  // Reset, then stream n samples of an 8-periodic pattern and confirm all were seen.
  task automatic seq(logic [31:0] phi, int s[8], int c[8], int n);
    phi_inc_i = phi;
    do_reset(2);
    for (int i = 0; i < n; i++) push(s[i % 8], c[i % 8]);
    repeat (n + 2) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  int qs[8] = '{0, 8191, 0, -8191, 0, 8191, 0, -8191};
  int qc[8] = '{8191, 0, -8191, 0, 8191, 0, -8191, 0};
  int es[8] = '{0, 5792, 8191, 5792, 0, -5792, -8191, -5792};
  int ec[8] = '{8191, 5792, 0, -5792, -8191, -5792, 0, 5792};
  int ns[8] = '{0, -8191, 0, 8191, 0, -8191, 0, 8191};
  int dz[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int df[8] = '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191};

  initial begin
    reset_n   = 1'b0;
    clken     = 1'b1;
    phi_inc_i = 32'h2AF;
    do_reset(7);
    // Slow tone: p stays 0 for samples 0..1526, becomes 1 at sample 1527 (T[1]=13, T[1023]=8191).
    for (int i = 0; i < 1600; i++) push(i < 1527 ? 0 : 13, 8191);
    tick();
    chk("valid_edge1", int'(out_valid), 0);
    tick();
    chk("valid_edge2", int'(out_valid), 0);
    tick();
    chk("valid_edge3", int'(out_valid), 1);
    repeat (1599) tick();
    chk("slow_drained", q.size(), 0);
    seq(32'h4000_0000, qs, qc, 12);
    seq(32'h2000_0000, es, ec, 16);
    seq(32'hC000_0000, ns, qc, 8);
    seq(32'h0, dz, df, 10);
    // Clock-enable freeze mid-run.
    phi_inc_i = 32'h4000_0000;
    do_reset(2);
    for (int i = 0; i < 12; i++) push(qs[i % 8], qc[i % 8]);
    repeat (6) tick();
    clken = 1'b0;
    repeat (5) begin
      tick();
      chk("hold_fsin", int'($signed(fsin_o)), -8191);
      chk("hold_fcos", int'($signed(fcos_o)), 0);
      chk("hold_valid", int'(out_valid), 1);
    end
    chk("hold_last_s", last.s, -8191);
    clken = 1'b1;
    repeat (8) tick();
    chk("clken_drained", q.size(), 0);
    // Mid-run reset restarts at phase 0.
    do_reset(2);
    for (int i = 0; i < 8; i++) push(qs[i], qc[i]);
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_fsin", int'(fsin_o), 0);
    chk("midrst_fcos", int'(fcos_o), 0);
    chk("midrst_valid", int'(out_valid), 0);
    q.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) push(qs[i], qc[i]);
    repeat (6) tick();
    chk("midrst_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
